rf_op_sequencer: RTL
====================

# rf_op_sequencer

Multi-cycle controller that executes register-to-register operations on the 8-entry × 8-bit register-file datapath. The register file has a single synchronous read port and a single write port. The block accepts one operation request (src1, src2, dst, op) over a valid/ready handshake and sequences it as: two register-file reads, an ALU step, a write-back, and a one-cycle done pulse. It sits between the top-level stimulus/control logic and the register file, replacing free-running address-driven compute with explicit, ordered transactions.

## Interface
Parameters:
- DATA_W, 8, register and result width
- ADDR_W, 3, register address width (2^ADDR_W entries)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_src1  in  ADDR_W  first operand address
- req_src2  in  ADDR_W  second operand address
- req_dst  in  ADDR_W  destination address
- req_op  in  2  00 ADD, 01 SUB, 10 AND, 11 XOR
- rf_raddr  out  ADDR_W  register-file read address; data returns next cycle
- rf_rdata  in  DATA_W  register-file read data
- rf_we  out  1  write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion
- result  out  DATA_W  last completed result; held until the next done
- carry  out  1  ADD carry-out / SUB borrow; 0 for AND and XOR; held with result

## Operation
States: IDLE → RD_A → RD_B → CAP_B → EXEC → WB → DONE → IDLE.
- **IDLE:** req_ready=1. A transfer occurs when req_valid && req_ready; latch src1, src2, dst and op, then go to RD_A. With no valid request, stay in IDLE.
- **RD_A:** rf_raddr=src1.
- **RD_B:** rf_raddr=src2; capture rf_rdata into opa.
- **CAP_B:** capture rf_rdata into opb.
- **EXEC:** result_next and carry_next are computed from opa and opb and registered.
  - ADD: {carry, result} = opa + opb, 9-bit sum.
  - SUB: result = (opa − opb) mod 256; carry = (opa < opb).
  - AND, XOR: bitwise; carry = 0.
- **WB:** rf_we=1, rf_waddr=dst, rf_wdata=registered result.
- **DONE:** done=1 for this cycle only; the result and carry outputs update at entry to DONE.
- Outside RD_A and RD_B, rf_raddr holds its last value. Outside WB, rf_we=0.
- src1==src2: both reads are still performed.
- dst equal to a source: allowed. Both reads complete before WB, so the old values are used.
- Request inputs are sampled only on the accept cycle. Changes to req_* while busy are ignored.

## Timing
- Accept at edge T. The FSM is in RD_A during cycle T+1, WB during T+5 and DONE during T+6. done is high in cycle T+6.
- The next accept can occur at the earliest in cycle T+7. Peak throughput is 1 op per 7 cycles.
- rf_we = (state==WB) && !rst. If rst is high during the WB cycle, no write occurs.
- Reset (synchronous, any state): next state IDLE. Outputs after reset:
  - req_ready=1, busy=0, done=0, rf_we=0
  - rf_raddr=0, rf_waddr=0, rf_wdata=0
  - result=0x00, carry=0
  - The in-flight operation is discarded.
- req_valid asserted while rst is high is not accepted.

## Structure
- Package rf_seq_pkg holds:
  - state enum (IDLE, RD_A, RD_B, CAP_B, EXEC, WB, DONE)
  - op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11
  - DATA_W and ADDR_W defaults
- Sub-module seq_alu: combinational; inputs opa, opb, op; outputs res and carry. It is instantiated once in EXEC-path logic.
- The register file is external and is not part of this block.

## Test plan
The bench uses a register-file model with 1-cycle read latency, preloaded with R0=0x05, R1=0x03, R6=0x02, R7=0xFF.
- **Basic ADD:** ADD src1=0, src2=1, dst=2, accepted at T → rf_we at T+5 with waddr=2, wdata=0x08; done at T+6; result=0x08, carry=0.
- **Overflow and borrow:** ADD 7,7 → dst 3 → wdata 0xFE, carry=1. Then SUB 1,0 → dst 4 → wdata 0xFE, carry=1 (borrow). Then SUB 7,6 → 0xFD, carry=0.
- **Logic and aliasing:** XOR 7,0 → dst 7 → R7 becomes 0xFA. A following AND 7,7 → dst 5 reads 0xFA and writes 0xFA, carry=0.
- **Back-to-back:** req_valid held high with two requests → req_ready low from T+1 to T+6. The second accept happens at T+7; exactly one rf_we per request.
- **Reset mid-op:** assert rst for one cycle during WB → no rf_we pulse, no done. Next cycle: IDLE, req_ready=1, result=0x00, carry=0. The destination register is unchanged.
- **Ignore while busy:** change req_src1 and req_op during RD_B → the operation completes using the originally latched values.

Source files
------------

// File: rtl/rf_op_sequencer_pkg.sv
// rf_seq_pkg
// Shared types and defaults for the register-file operation sequencer.
// It holds the FSM state encoding, the two-bit operation codes carried on
// req_op, and the default data/address widths.
package rf_seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CAP_B,
    EXEC,
    WB,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

endpackage

// File: rtl/rf_op_sequencer_seq_alu.sv
// seq_alu
// Combinational ALU used during the execute step of the sequencer.
// Ports:
//   opa, opb : DATA_W-bit operands
//   op       : operation select (ADD, SUB, AND, XOR)
//   res      : DATA_W-bit result
//   carry    : ADD carry-out, SUB borrow (opa < opb), 0 for logic ops
module seq_alu
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  input  op_e               op,
  output logic [DATA_W-1:0] res,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Both arithmetic results are formed one bit wider. For the subtraction
  // the extra top bit goes high exactly when opa < opb, which is the borrow.
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // Select the result for the requested operation; logic ops never carry.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        res   = diff[DATA_W-1:0];
        carry = diff[DATA_W];
      end
      OP_AND: res = opa & opb;
      OP_XOR: res = opa ^ opb;
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer
// Multi-cycle controller that takes one register-to-register operation over
// a valid/ready handshake and runs it against an external register file
// with one synchronous read port and one write port:
//   IDLE -> RD_A -> RD_B -> CAP_B -> EXEC -> WB -> DONE -> IDLE
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid / req_ready        : request handshake (ready only in IDLE)
//   req_src1, req_src2, req_dst  : operand and destination addresses
//   req_op                       : 00 ADD, 01 SUB, 10 AND, 11 XOR
//   rf_raddr / rf_rdata          : read port, data returns one cycle later
//   rf_we, rf_waddr, rf_wdata    : write port, pulsed in WB
//   busy, done                   : status; done is a one-cycle pulse
//   result, carry                : last completed result, held until next done
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_src1,
  input  logic [ADDR_W-1:0] req_src2,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [1:0]        req_op,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  state_e state_q;
  state_e state_d;

  logic              accept;
  logic [ADDR_W-1:0] raddr_q;
  logic [ADDR_W-1:0] src2_q;
  logic [ADDR_W-1:0] dst_q;
  op_e               op_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wcarry_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign accept = (state_q == IDLE) && req_valid;

  // State register. Reset wins from any state and discards the in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a fixed walk through the steps once a request is taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RD_A;
      RD_A:    state_d = RD_B;
      RD_B:    state_d = CAP_B;
      CAP_B:   state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .opa   (opa_q),
    .opb   (opb_q),
    .op    (op_q),
    .res   (alu_res),
    .carry (alu_carry)
  );

  // Datapath registers. The read address register doubles as the latch for
  // src1: it is loaded on accept so src1 is already on the read port during
  // RD_A, then switched to src2 for RD_B, and otherwise just holds. The
  // operands arrive one cycle after their address, hence the capture in
  // RD_B and CAP_B. The visible result/carry are loaded during WB so they
  // change exactly as the FSM enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      raddr_q  <= '0;
      src2_q   <= '0;
      dst_q    <= '0;
      op_q     <= OP_ADD;
      opa_q    <= '0;
      opb_q    <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wcarry_q <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      if (accept) begin
        raddr_q <= req_src1;
        src2_q  <= req_src2;
        dst_q   <= req_dst;
        op_q    <= op_e'(req_op);
      end
      case (state_q)
        RD_A:  raddr_q <= src2_q;
        RD_B:  opa_q   <= rf_rdata;
        CAP_B: opb_q   <= rf_rdata;
        EXEC: begin
          wdata_q  <= alu_res;
          wcarry_q <= alu_carry;
          waddr_q  <= dst_q;
        end
        WB: begin
          result_q <= wdata_q;
          carry_q  <= wcarry_q;
        end
        default: ;
      endcase
    end
  end

  // The write strobe is gated by reset so a reset landing in WB suppresses
  // the write in that same cycle.
  assign rf_we     = (state_q == WB) && !rst;
  assign rf_raddr  = raddr_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry     = carry_q;

endmodule
